// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU datapath blocks.
// Holds the operand width, the multiplier FSM state encoding and the
// number of shift-and-add steps performed per multiply.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int MUL_STEPS = 32;
    localparam int MUL_CNT_W = 5;

    // Step counter value on the final shift-and-add step.
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_LAST = 5'd31;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = MUL_IDLE,
        ST_RUN     = MUL_RUN,
        ST_DONE    = MUL_DONE,
        ST_ILLEGAL = 2'd3
    } mul_state_e;

endpackage : alu_pkg

// File: rtl/seq_mul32_adder.sv
// thirtyTwoBitAdder: the ALU's 32-bit adder, S + Cout = A + B + Cin.
// Ports:
//   A, B  in  32 : addends
//   Cin   in  1  : carry in
//   S     out 32 : sum
//   Cout  out 1  : carry out
module thirtyTwoBitAdder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {32'd0, Cin};

endmodule : thirtyTwoBitAdder

// File: rtl/seq_mul32.sv
// seq_mul32: sequential unsigned 32x32 -> 64-bit shift-and-add multiplier.
// One partial-product step per clock through a single thirtyTwoBitAdder.
// Ports:
//   clk      in  1   : clock, rising edge
//   rst      in  1   : asynchronous active-high reset
//   start    in  1   : launch a multiply (sampled only in IDLE)
//   a        in  32  : multiplicand, captured on the accepting edge
//   b        in  32  : multiplier, captured on the accepting edge
//   busy     out 1   : high while an operation is in RUN or DONE
//   done     out 1   : one-cycle pulse when product updates
//   product  out 64  : registered result, held until the next completion
// WIDTH must stay 32: the adder it drives is fixed at 32 bits.
module seq_mul32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_e               state_q,   state_d;
    logic [WIDTH-1:0]         acc_q,     acc_d;
    logic [WIDTH-1:0]         mq_q,      mq_d;
    logic [WIDTH-1:0]         mcand_q,   mcand_d;
    logic [MUL_CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]       product_q, product_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    logic [WIDTH-1:0]         add_b_s;
    logic [WIDTH-1:0]         add_sum_s;
    logic                     add_cout_s;
    logic [2*WIDTH-1:0]       step_s;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b_s = mq_q[0] ? mcand_q : {WIDTH{1'b0}};

    thirtyTwoBitAdder u_adder (
        .A    (acc_q),
        .B    (add_b_s),
        .Cin  (1'b0),
        .S    (add_sum_s),
        .Cout (add_cout_s)
    );

    // 65-bit {Cout, S, mq} shifted right by one: Cout lands in acc[31].
    assign step_s = {add_cout_s, add_sum_s, mq_q[WIDTH-1:1]};

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {MUL_CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                {acc_d, mq_d} = step_s;
                // Wraps 31 -> 0 on the final step; unused until the next load.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MUL_CNT_LAST) begin
                    product_d = step_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flags are registered from the next state so they line up with it.
        busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= {WIDTH{1'b0}};
            mq_q      <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            cnt_q     <= {MUL_CNT_W{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mul32
